button_events: RTL and testbench

//  Input-side companion to the LED PWM sequencer. It turns the raw pwr_button pin into clean user events.
//  - 2-FF synchroniser, then a debouncer, then a press-classification FSM.
//  - Emits SHORT / LONG / REPEAT event codes through a single-entry valid/ready holding register.
//  - Sits between the board pin and any mode/brightness controller. Board clock is 25 MHz.

---
 rtl/button_pkg.sv | 17 +
 rtl/button_debounce.sv | 46 ++++
 rtl/button_events.sv | 127 ++++++++++++
 tb/tb_button_events.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types for the button event path: event codes and press-classifier states.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_SHORT  = 2'd1,
    EVT_LONG   = 2'd2,
    EVT_REPEAT = 2'd3
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/button_debounce.sv
// Pin polarity normalisation, 2-FF synchroniser and debounce counter.
// stable is the accepted pressed level (1 = pressed).
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic stable
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pin;
  logic          sync1;
  logic          raw_s;
  logic [CW-1:0] cnt;

  // Invert before the synchroniser so every stage downstream sees pressed = 1.
  assign pin = btn_in ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      raw_s  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= pin;
      raw_s <= sync1;
      if (raw_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= raw_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_events.sv
// Turns the raw button pin into SHORT / LONG / REPEAT events behind a
// single-entry valid/ready holding register with a sticky overflow flag.
module button_events
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LONG_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 6_250_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic       evt_overflow,
  input  logic       overflow_clr
);

  localparam int            HW        = $clog2(LONG_CYCLES + 1);
  localparam int            RW        = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  logic stable;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_in),
    .stable(stable)
  );

  assign btn_level = stable;

  fsm_state_t    state, state_nx;
  logic [HW-1:0] hold_ctr, hold_nx;
  logic [RW-1:0] rep_ctr, rep_nx;
  logic          emit;
  evt_code_t     emit_code;
  evt_code_t     code_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_ctr <= '0;
      rep_ctr  <= '0;
    end else begin
      state    <= state_nx;
      hold_ctr <= hold_nx;
      rep_ctr  <= rep_nx;
    end
  end

  // Release is tested first in HELD and LONG so it wins over a same-cycle terminal count.
  always_comb begin
    state_nx  = state;
    hold_nx   = hold_ctr;
    rep_nx    = rep_ctr;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    case (state)
      ST_IDLE: begin
        if (stable) begin
          state_nx = ST_HELD;
          hold_nx  = '0;
        end
      end
      ST_HELD: begin
        hold_nx = hold_ctr + 1'b1;
        if (!stable) begin
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          state_nx  = ST_IDLE;
        end else if (hold_ctr == HOLD_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_nx  = ST_LONG;
          rep_nx    = '0;
        end
      end
      ST_LONG: begin
        rep_nx = rep_ctr + 1'b1;
        if (!stable) begin
          state_nx = ST_IDLE;
        end else if (rep_ctr == REP_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          rep_nx    = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A full, un-popped register drops the incoming event; a pop in the same
  // cycle makes room so the new event loads with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid    <= 1'b0;
      code_q       <= EVT_NONE;
      evt_overflow <= 1'b0;
    end else begin
      if (emit) begin
        if (evt_valid && !evt_ready) begin
          evt_overflow <= 1'b1;
        end else begin
          evt_valid <= 1'b1;
          code_q    <= emit_code;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
        code_q    <= EVT_NONE;
      end
      if (overflow_clr && !(emit && evt_valid && !evt_ready))
        evt_overflow <= 1'b0;
    end
  end

  assign evt_code = code_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with short debounce/hold/repeat lengths;
// a second instance exercises the active-low pin polarity.
module tb_button_events;

  logic       clk, rst_n, btn, btn_al, evt_ready, overflow_clr;
  logic       lvl0, vld0, ovf0;
  logic [1:0] code0;
  logic       lvl1, vld1, ovf1;
  logic [1:0] code1;

  int checks   = 0;
  int failures = 0;

  button_events #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn), .btn_level(lvl0),
    .evt_valid(vld0), .evt_ready(evt_ready), .evt_code(code0),
    .evt_overflow(ovf0), .overflow_clr(overflow_clr)
  );

  button_events #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_al), .btn_level(lvl1),
    .evt_valid(vld1), .evt_ready(evt_ready), .evt_code(code1),
    .evt_overflow(ovf1), .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 1'b0; btn_al = 1'b1; evt_ready = 1'b1; overflow_clr = 1'b0;
    step();
    step();
    checks++;
    if ({lvl0, vld0, code0, ovf0} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {lvl0, vld0, code0, ovf0});
    end
    checks++;
    if ({lvl1, vld1, code1, ovf1} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs_al got=%b exp=00000", {lvl1, vld1, code1, ovf1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      btn = (k < 20) ? ~k[1] : 1'b0;
      step();
      checks++;
      if (lvl0 !== 1'b0 || vld0 !== 1'b0) begin
        failures++;
        $display("FAIL bounce k=%0d level=%b valid=%b exp=0/0", k, lvl0, vld0);
      end
    end
  endtask

  // Clean press at k=0, release after k=10; al selects the active-low instance.
  task automatic test_short_press(input bit al);
    logic       lvl, vld, exp_lvl, exp_vld;
    logic [1:0] code;
    if (al) btn_al = 1'b0; else btn = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      lvl  = al ? lvl1 : lvl0;
      vld  = al ? vld1 : vld0;
      code = al ? code1 : code0;
      exp_lvl = (k >= 6 && k < 16);
      exp_vld = (k == 17);
      checks++;
      if (lvl !== exp_lvl) begin
        failures++;
        $display("FAIL short_level al=%0d k=%0d got=%b exp=%b", al, k, lvl, exp_lvl);
      end
      checks++;
      if (vld !== exp_vld) begin
        failures++;
        $display("FAIL short_valid al=%0d k=%0d got=%b exp=%b", al, k, vld, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (code !== 2'd1) begin
          failures++;
          $display("FAIL short_code al=%0d got=%0d exp=1", al, code);
        end
      end
      if (k == 10) begin
        if (al) btn_al = 1'b1; else btn = 1'b0;
      end
    end
  endtask

  task automatic test_long_repeat();
    int   events;
    logic exp_lvl, exp_vld;
    logic [1:0] exp_code;
    events = 0;
    btn = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_lvl  = (k >= 6 && k < 56);
      exp_vld  = (k == 27 || k == 35 || k == 43 || k == 51);
      exp_code = (k == 27) ? 2'd2 : 2'd3;
      if (vld0) events++;
      checks++;
      if (lvl0 !== exp_lvl) begin
        failures++;
        $display("FAIL long_level k=%0d got=%b exp=%b", k, lvl0, exp_lvl);
      end
      checks++;
      if (vld0 !== exp_vld) begin
        failures++;
        $display("FAIL long_valid k=%0d got=%b exp=%b", k, vld0, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (code0 !== exp_code) begin
          failures++;
          $display("FAIL long_code k=%0d got=%0d exp=%0d", k, code0, exp_code);
        end
      end
      if (k == 50) btn = 1'b0;
    end
    checks++;
    if (events != 4) begin
      failures++;
      $display("FAIL long_event_count got=%0d exp=4", events);
    end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    btn = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k == 5)  btn = 1'b0;
      if (k == 15) btn = 1'b1;
      if (k == 20) btn = 1'b0;
      if (k == 11) begin
        checks++;
        if (vld0 !== 1'b0) begin
          failures++;
          $display("FAIL ovf_pre_valid got=%b exp=0", vld0);
        end
      end
      if (k == 12 || k == 26) begin
        checks++;
        if ({vld0, code0, ovf0} !== 4'b1010) begin
          failures++;
          $display("FAIL ovf_first_held k=%0d got=%b exp=1010", k, {vld0, code0, ovf0});
        end
      end
      if (k == 27 || k == 35) begin
        checks++;
        if ({vld0, code0, ovf0} !== 4'b1011) begin
          failures++;
          $display("FAIL ovf_dropped k=%0d got=%b exp=1011", k, {vld0, code0, ovf0});
        end
      end
    end
    evt_ready = 1'b1;
    step();
    checks++;
    if ({vld0, ovf0} !== 2'b01) begin
      failures++;
      $display("FAIL ovf_pop got=%b exp=01", {vld0, ovf0});
    end
    step(); step(); step();
    checks++;
    if ({vld0, ovf0} !== 2'b01) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=01", {vld0, ovf0});
    end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    checks++;
    if (ovf0 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", ovf0);
    end
  endtask

  // Held SHORT is popped in the same cycle a LONG arrives: LONG replaces it with no gap.
  task automatic test_back_to_back();
    evt_ready = 1'b0;
    btn = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      step();
      if (k == 5)  btn = 1'b0;
      if (k == 15) btn = 1'b1;
      if (k == 41) begin
        checks++;
        if ({vld0, code0} !== 3'b101) begin
          failures++;
          $display("FAIL b2b_held got=%b exp=101", {vld0, code0});
        end
        evt_ready = 1'b1;
      end
      if (k == 42) begin
        checks++;
        if ({vld0, code0, ovf0} !== 4'b1100) begin
          failures++;
          $display("FAIL b2b_load got=%b exp=1100", {vld0, code0, ovf0});
        end
        btn = 1'b0;
      end
      if (k >= 43) begin
        checks++;
        if ({vld0, ovf0} !== 2'b00) begin
          failures++;
          $display("FAIL b2b_after k=%0d got=%b exp=00", k, {vld0, ovf0});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_lvl, exp_vld;
    evt_ready = 1'b1;
    btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 27) begin
        checks++;
        if ({vld0, code0} !== 3'b110) begin
          failures++;
          $display("FAIL rst_pre_long got=%b exp=110", {vld0, code0});
        end
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({lvl0, vld0, code0, ovf0} !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=00000", {lvl0, vld0, code0, ovf0});
    end
    for (int k = 32; k <= 60; k++) begin
      step();
      exp_lvl = (k >= 37);
      exp_vld = (k == 58);
      checks++;
      if (lvl0 !== exp_lvl) begin
        failures++;
        $display("FAIL rst_relevel k=%0d got=%b exp=%b", k, lvl0, exp_lvl);
      end
      checks++;
      if (vld0 !== exp_vld) begin
        failures++;
        $display("FAIL rst_rehold k=%0d got=%b exp=%b", k, vld0, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (code0 !== 2'd2) begin
          failures++;
          $display("FAIL rst_rehold_code got=%0d exp=2", code0);
        end
      end
      if (k == 58) btn = 1'b0;
    end
    for (int k = 0; k < 12; k++) step();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_press(1'b0);
    test_long_repeat();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_short_press(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
